csi_rx_frame_ctrl: RTL and testbench



---
 rtl/csi_rx_pkg.sv | 22 ++
 rtl/csi_lock_timer.sv | 26 ++
 rtl/csi_rx_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_csi_rx_frame_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_rx_pkg.sv
// Shared data-type codes, frame controller states and small helpers for the CSI-2 RX path.
package csi_rx_pkg;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_LS    = 6'h02;
   localparam logic [5:0] DT_LE    = 6'h03;
   localparam logic [5:0] DT_RAW10 = 6'h2B;

   typedef enum logic [2:0] {
      RESET_WAIT,
      ARMED,
      FRAME,
      LINE,
      STOP
   } frame_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/csi_lock_timer.sv
// Counts consecutive pll_lock cycles; lock_done_c marks the LOCK_WAIT-th one.
module csi_lock_timer #(
   parameter int unsigned LOCK_WAIT = 64
) (
   input  logic byte_clk,
   input  logic byte_clk_rst,
   input  logic en,
   input  logic pll_lock,
   output logic lock_done_c
);

   localparam int unsigned CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

   logic [CW-1:0] cnt;

   assign lock_done_c = en && pll_lock && (cnt == CW'(LOCK_WAIT - 1));

   always_ff @(posedge byte_clk) begin
      if (byte_clk_rst || !en || !pll_lock || lock_done_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/csi_rx_frame_ctrl.sv
// Byte-clock frame controller: PLL bring-up, FS/FE tracking, DT-filtered payload
// forwarding, line/frame counting and protocol error pulses.
module csi_rx_frame_ctrl
   import csi_rx_pkg::*;
#(
   parameter int unsigned NUM_RX_LANE = 2,
   parameter int unsigned RX_GEAR     = 8,
   parameter int unsigned LOCK_WAIT   = 64,
   parameter int unsigned TIMEOUT_W   = 20
) (
   input  logic                            byte_clk,
   input  logic                            byte_clk_rst,
   input  logic                            pll_lock,
   input  logic                            capture_en,
   input  logic [5:0]                      ref_dt,
   input  logic                            sp_en,
   input  logic                            lp_av_en,
   input  logic                            payload_en,
   input  logic [NUM_RX_LANE*RX_GEAR-1:0]  payload,
   input  logic [5:0]                      dt,
   input  logic [15:0]                     wc,
   output logic                            tx_rdy,
   output logic                            frame_active,
   output logic                            vid_payload_en,
   output logic [NUM_RX_LANE*RX_GEAR-1:0]  vid_payload,
   output logic [15:0]                     line_cnt,
   output logic [15:0]                     frame_cnt,
   output logic                            err_orphan_fe,
   output logic                            err_nested_fs,
   output logic                            err_short_line,
   output logic                            err_timeout
);

   localparam int unsigned DW    = NUM_RX_LANE * RX_GEAR;
   localparam int unsigned BYTES = DW / 8;
   localparam int unsigned BCW   = 17;

   frame_state_t         state;
   logic [15:0]          wc_q;
   logic [BCW-1:0]       byte_cnt;
   logic [TIMEOUT_W-1:0] stall;

   logic                 lock_done_c;
   logic                 in_frame_c;
   logic                 strobe_c;
   logic                 is_fs_c;
   logic                 is_fe_c;
   logic                 timeout_c;
   logic [TIMEOUT_W-1:0] stall_inc_c;
   logic [BCW:0]         byte_sum_c;

   csi_lock_timer #(
      .LOCK_WAIT (LOCK_WAIT)
   ) u_lock_timer (
      .byte_clk     (byte_clk),
      .byte_clk_rst (byte_clk_rst),
      .en           (state == RESET_WAIT),
      .pll_lock     (pll_lock),
      .lock_done_c  (lock_done_c)
   );

   assign in_frame_c  = (state == FRAME) || (state == LINE);
   assign strobe_c    = sp_en || lp_av_en || payload_en;
   assign is_fs_c     = sp_en && (dt == DT_FS);
   assign is_fe_c     = sp_en && (dt == DT_FE);
   assign stall_inc_c = stall + TIMEOUT_W'(1);
   // Fires on the idle cycle that brings the stall count to all-ones; a strobe always wins.
   assign timeout_c   = in_frame_c && !strobe_c && (&stall_inc_c);
   assign byte_sum_c  = {1'b0, byte_cnt} + (BCW+1)'(BYTES);

   always_ff @(posedge byte_clk) begin
      if (byte_clk_rst) begin
         state          <= RESET_WAIT;
         tx_rdy         <= 1'b0;
         frame_active   <= 1'b0;
         vid_payload_en <= 1'b0;
         vid_payload    <= '0;
         line_cnt       <= '0;
         frame_cnt      <= '0;
         err_orphan_fe  <= 1'b0;
         err_nested_fs  <= 1'b0;
         err_short_line <= 1'b0;
         err_timeout    <= 1'b0;
         wc_q           <= '0;
         byte_cnt       <= '0;
         stall          <= '0;
      end else begin
         err_orphan_fe  <= 1'b0;
         err_nested_fs  <= 1'b0;
         err_short_line <= 1'b0;
         err_timeout    <= 1'b0;
         vid_payload_en <= 1'b0;
         if (in_frame_c) begin
            stall <= strobe_c ? '0 : stall_inc_c;
         end

         if (!pll_lock) begin
            state        <= RESET_WAIT;
            tx_rdy       <= 1'b0;
            frame_active <= 1'b0;
         end else if (timeout_c) begin
            err_timeout  <= 1'b1;
            frame_active <= 1'b0;
            state        <= ARMED;
         end else begin
            case (state)
               RESET_WAIT: begin
                  if (lock_done_c) begin
                     tx_rdy <= 1'b1;
                     state  <= ARMED;
                  end
               end
               ARMED: begin
                  if (is_fs_c && capture_en) begin
                     state        <= FRAME;
                     frame_active <= 1'b1;
                     line_cnt     <= '0;
                     stall        <= '0;
                  end else if (is_fe_c) begin
                     err_orphan_fe <= 1'b1;
                  end
               end
               FRAME: begin
                  if (is_fe_c) begin
                     frame_cnt    <= frame_cnt + 16'd1;
                     frame_active <= 1'b0;
                     state        <= capture_en ? ARMED : STOP;
                  end else if (is_fs_c) begin
                     err_nested_fs <= 1'b1;
                     line_cnt      <= '0;
                  end else if (lp_av_en && (dt == ref_dt)) begin
                     wc_q     <= wc;
                     byte_cnt <= '0;
                     state    <= LINE;
                  end
               end
               LINE: begin
                  if (payload_en) begin
                     vid_payload_en <= 1'b1;
                     vid_payload    <= payload;
                     byte_cnt       <= byte_sum_c[BCW] ? '1 : byte_sum_c[BCW-1:0];
                  end else begin
                     line_cnt       <= sat_inc16(line_cnt);
                     err_short_line <= (byte_cnt < {1'b0, wc_q});
                     state          <= FRAME;
                  end
               end
               STOP: begin
                  if (capture_en) begin
                     state <= ARMED;
                  end
               end
               default: state <= RESET_WAIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csi_rx_frame_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic scored against a rule-level reference model.
`timescale 1ns/1ps
module tb_csi_rx_frame_ctrl;
   import csi_rx_pkg::*;

   localparam int unsigned NUM_RX_LANE = 2;
   localparam int unsigned RX_GEAR     = 8;
   localparam int unsigned LOCK_WAIT   = 64;
   localparam int unsigned TIMEOUT_W   = 8;
   localparam int unsigned PW          = NUM_RX_LANE * RX_GEAR;
   localparam int          BYTES       = PW / 8;
   localparam int          TMO         = (1 << TIMEOUT_W) - 1;

   logic          byte_clk = 1'b0;
   logic          byte_clk_rst;
   logic          pll_lock;
   logic          capture_en;
   logic [5:0]    ref_dt;
   logic          sp_en, lp_av_en, payload_en;
   logic [PW-1:0] payload;
   logic [5:0]    dt;
   logic [15:0]   wc;
   logic          tx_rdy, frame_active, vid_payload_en;
   logic [PW-1:0] vid_payload;
   logic [15:0]   line_cnt, frame_cnt;
   logic          err_orphan_fe, err_nested_fs, err_short_line, err_timeout;

   int checks   = 0;
   int failures = 0;
   int beats_seen;

   // reference model state (expressed in terms of the frame rules)
   bit            m_ready, m_in_frame, m_in_line, m_stopped;
   int            m_lock_run, m_idle, m_bytes, m_wc;
   logic          e_tx, e_fa, e_ven;
   logic [PW-1:0] e_vpay;
   logic [15:0]   e_line, e_frame;
   logic [3:0]    e_err;

   typedef struct {
      logic        sp, lp, pe;
      logic [5:0]  d;
      logic [15:0] w;
      logic        fa, ven;
      logic [15:0] ln, fr;
      logic [3:0]  er;
   } vec_t;
   vec_t tbl[$];

   csi_rx_frame_ctrl #(
      .NUM_RX_LANE (NUM_RX_LANE),
      .RX_GEAR     (RX_GEAR),
      .LOCK_WAIT   (LOCK_WAIT),
      .TIMEOUT_W   (TIMEOUT_W)
   ) dut (
      .byte_clk       (byte_clk),
      .byte_clk_rst   (byte_clk_rst),
      .pll_lock       (pll_lock),
      .capture_en     (capture_en),
      .ref_dt         (ref_dt),
      .sp_en          (sp_en),
      .lp_av_en       (lp_av_en),
      .payload_en     (payload_en),
      .payload        (payload),
      .dt             (dt),
      .wc             (wc),
      .tx_rdy         (tx_rdy),
      .frame_active   (frame_active),
      .vid_payload_en (vid_payload_en),
      .vid_payload    (vid_payload),
      .line_cnt       (line_cnt),
      .frame_cnt      (frame_cnt),
      .err_orphan_fe  (err_orphan_fe),
      .err_nested_fs  (err_nested_fs),
      .err_short_line (err_short_line),
      .err_timeout    (err_timeout)
   );

   always #5 byte_clk = ~byte_clk;

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] obs();
      return 64'({tx_rdy, frame_active, vid_payload_en, vid_payload, line_cnt, frame_cnt,
                  err_orphan_fe, err_nested_fs, err_short_line, err_timeout});
   endfunction

   function automatic logic [63:0] expv();
      return 64'({e_tx, e_fa, e_ven, e_vpay, e_line, e_frame, e_err});
   endfunction

   task automatic model_reset();
      m_ready = 0; m_in_frame = 0; m_in_line = 0; m_stopped = 0;
      m_lock_run = 0; m_idle = 0; m_bytes = 0; m_wc = 0;
      e_tx = 0; e_fa = 0; e_ven = 0; e_vpay = '0; e_line = '0; e_frame = '0; e_err = '0;
   endtask

   // Predicts the registered outputs after the coming edge from the current inputs.
   task automatic model_edge();
      bit strobe;
      strobe = sp_en || lp_av_en || payload_en;
      e_err  = '0;
      e_ven  = 1'b0;
      if (!pll_lock) begin
         m_lock_run = 0; m_ready = 0; m_in_frame = 0; m_in_line = 0; m_stopped = 0;
         e_tx = 0; e_fa = 0;
      end else if (!m_ready) begin
         m_lock_run++;
         if (m_lock_run >= LOCK_WAIT) begin
            m_ready = 1; e_tx = 1;
         end
      end else if (m_stopped) begin
         if (capture_en) m_stopped = 0;
      end else if (!m_in_frame) begin
         if (sp_en && dt == DT_FS && capture_en) begin
            m_in_frame = 1; e_fa = 1; e_line = '0; m_idle = 0;
         end else if (sp_en && dt == DT_FE) begin
            e_err[3] = 1'b1;
         end
      end else begin
         m_idle = strobe ? 0 : m_idle + 1;
         if (m_idle >= TMO) begin
            e_err[0] = 1'b1; m_in_frame = 0; m_in_line = 0; e_fa = 0;
         end else if (m_in_line) begin
            if (payload_en) begin
               e_ven   = 1'b1;
               e_vpay  = payload;
               m_bytes = (m_bytes + BYTES > 131071) ? 131071 : m_bytes + BYTES;
            end else begin
               if (e_line != 16'hFFFF) e_line = e_line + 16'd1;
               if (m_bytes < m_wc) e_err[1] = 1'b1;
               m_in_line = 0;
            end
         end else if (sp_en && dt == DT_FE) begin
            e_frame = e_frame + 16'd1; m_in_frame = 0; e_fa = 0; m_stopped = !capture_en;
         end else if (sp_en && dt == DT_FS) begin
            e_err[2] = 1'b1; e_line = '0;
         end else if (lp_av_en && dt == ref_dt) begin
            m_in_line = 1; m_wc = int'(wc); m_bytes = 0;
         end
      end
   endtask

   task automatic step(input logic sp, input logic lp, input logic pe, input logic [5:0] d,
                       input logic [15:0] w, input logic [PW-1:0] p, input string tag);
      sp_en = sp; lp_av_en = lp; payload_en = pe; dt = d; wc = w; payload = p;
      model_edge();
      @(posedge byte_clk);
      #1;
      check(tag, obs(), expv());
      beats_seen += int'(vid_payload_en);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 6'h00, 16'd0, '0, "idle");
   endtask

   task automatic short_pkt(input logic [5:0] d, input string tag);
      step(1'b1, 1'b0, 1'b0, d, 16'd0, '0, tag);
   endtask

   task automatic send_line(input logic [5:0] d, input logic [15:0] w, input int nbeats);
      step(1'b0, 1'b1, 1'b0, d, w, '0, "lp_hdr");
      for (int b = 0; b < nbeats; b++) step(1'b0, 1'b0, 1'b1, 6'h00, 16'd0, PW'($urandom), "beat");
      idle(1);
   endtask

   function automatic vec_t mk(input logic sp, input logic lp, input logic pe, input logic [5:0] d,
                               input logic [15:0] w, input logic fa, input logic ven,
                               input logic [15:0] ln, input logic [15:0] fr, input logic [3:0] er);
      vec_t v;
      v.sp = sp; v.lp = lp; v.pe = pe; v.d = d; v.w = w;
      v.fa = fa; v.ven = ven; v.ln = ln; v.fr = fr; v.er = er;
      return v;
   endfunction

   initial begin
      // rows: inputs, then expected {frame_active, vid_en, line_cnt, frame_cnt, err{orph,nest,short,tmo}}
      tbl.push_back(mk(1, 0, 0, DT_FE, 16'd0, 0, 0, 16'd0, 16'd0, 4'b1000));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 0, 0, 16'd0, 16'd0, 4'b0000));
      tbl.push_back(mk(1, 0, 0, DT_FS, 16'd0, 1, 0, 16'd0, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 1, 0, 16'd0, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 1, 0, DT_RAW10, 16'd10, 1, 0, 16'd0, 16'd0, 4'b0000));
      for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 1, 6'h00, 16'd0, 1, 1, 16'd0, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 1, 0, 16'd1, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 1, 0, 6'h12, 16'd10, 1, 0, 16'd1, 16'd0, 4'b0000));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 1, 6'h00, 16'd0, 1, 0, 16'd1, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 1, 0, 16'd1, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 1, 0, DT_RAW10, 16'd10, 1, 0, 16'd1, 16'd0, 4'b0000));
      for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 1, 6'h00, 16'd0, 1, 1, 16'd1, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 1, 0, 16'd2, 16'd0, 4'b0010));
      tbl.push_back(mk(1, 0, 0, DT_FS, 16'd0, 1, 0, 16'd0, 16'd0, 4'b0100));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 1, 0, 16'd0, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 1, 0, DT_RAW10, 16'd3, 1, 0, 16'd0, 16'd0, 4'b0000));
      for (int k = 0; k < 2; k++) tbl.push_back(mk(0, 0, 1, 6'h00, 16'd0, 1, 1, 16'd0, 16'd0, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 1, 0, 16'd1, 16'd0, 4'b0000));
      tbl.push_back(mk(1, 0, 0, DT_FE, 16'd0, 0, 0, 16'd1, 16'd1, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 6'h00, 16'd0, 0, 0, 16'd1, 16'd1, 4'b0000));

      byte_clk_rst = 1'b1; pll_lock = 1'b0; capture_en = 1'b1; ref_dt = DT_RAW10;
      sp_en = 1'b0; lp_av_en = 1'b0; payload_en = 1'b0; payload = '0; dt = '0; wc = '0;
      beats_seen = 0;
      repeat (3) @(posedge byte_clk);
      #1;
      check("reset_state", obs(), 64'd0);
      byte_clk_rst = 1'b0;
      model_reset();

      // bring-up with a lock drop after 30 cycles
      idle(3);
      pll_lock = 1'b1;
      idle(30);
      check("tx_rdy_before_drop", 64'(tx_rdy), 64'd0);
      pll_lock = 1'b0;
      idle(1);
      pll_lock = 1'b1;
      for (int i = 0; i < LOCK_WAIT; i++) begin
         idle(1);
         if (i == LOCK_WAIT - 2) check("tx_rdy_cycle63", 64'(tx_rdy), 64'd0);
         if (i == LOCK_WAIT - 1) check("tx_rdy_cycle64", 64'(tx_rdy), 64'd1);
      end

      // directed vector table
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].sp, tbl[i].lp, tbl[i].pe, tbl[i].d, tbl[i].w, PW'(40960 + i), $sformatf("vec%0d", i));
         check($sformatf("vec%0d_hand", i),
               64'({frame_active, vid_payload_en, line_cnt, frame_cnt,
                    err_orphan_fe, err_nested_fs, err_short_line, err_timeout,
                    vid_payload_en ? vid_payload : PW'(0)}),
               64'({tbl[i].fa, tbl[i].ven, tbl[i].ln, tbl[i].fr, tbl[i].er,
                    tbl[i].ven ? PW'(40960 + i) : PW'(0)}));
      end

      // nominal frame: 3 lines x 5 beats
      beats_seen = 0;
      short_pkt(DT_FS, "nom_fs");
      check("nom_fa_rise", 64'(frame_active), 64'd1);
      for (int l = 0; l < 3; l++) send_line(DT_RAW10, 16'd10, 5);
      check("nom_fa_before_fe", 64'(frame_active), 64'd1);
      short_pkt(DT_FE, "nom_fe");
      check("nom_beats", 64'(beats_seen), 64'd15);
      check("nom_counts", 64'({frame_active, line_cnt, frame_cnt}), 64'({1'b0, 16'd3, 16'd2}));
      idle(2);

      // capture_en dropped mid-frame: frame completes, then FS ignored until re-enabled
      short_pkt(DT_FS, "stop_fs");
      send_line(DT_RAW10, 16'd6, 3);
      capture_en = 1'b0;
      send_line(DT_RAW10, 16'd6, 3);
      short_pkt(DT_FE, "stop_fe");
      check("stop_frame_done", 64'({frame_active, frame_cnt}), 64'({1'b0, 16'd3}));
      idle(1);
      short_pkt(DT_FS, "stop_fs_ignored");
      check("stop_fs_ignored_hand", 64'(frame_active), 64'd0);
      idle(2);
      capture_en = 1'b1;
      idle(1);
      short_pkt(DT_FS, "rearm_fs");
      check("rearm_fa", 64'(frame_active), 64'd1);
      short_pkt(DT_FE, "rearm_fe");
      idle(1);

      // stall timeout: FS then silence
      short_pkt(DT_FS, "tmo_fs");
      for (int i = 0; i < TMO; i++) begin
         idle(1);
         if (i == TMO - 2) check("tmo_not_yet", 64'({err_timeout, frame_active}), 64'b01);
         if (i == TMO - 1) check("tmo_fire", 64'({err_timeout, frame_active, frame_cnt}), 64'({2'b10, 16'd4}));
      end
      idle(1);
      short_pkt(DT_FE, "tmo_then_fe");
      check("tmo_state_armed", 64'(err_orphan_fe), 64'd1);
      idle(1);

      // lock drop mid-line
      short_pkt(DT_FS, "drop_fs");
      step(1'b0, 1'b1, 1'b0, DT_RAW10, 16'd8, '0, "drop_hdr");
      step(1'b0, 1'b0, 1'b1, 6'h00, 16'd0, PW'(16'h1234), "drop_beat");
      pll_lock = 1'b0;
      step(1'b0, 1'b0, 1'b1, 6'h00, 16'd0, PW'(16'h5678), "drop_cycle");
      check("drop_hand", 64'({tx_rdy, frame_active, vid_payload_en, err_orphan_fe, err_nested_fs,
                              err_short_line, err_timeout}), 64'd0);
      pll_lock = 1'b1;
      idle(LOCK_WAIT + 2);

      // randomized traffic against the model
      for (int n = 0; n < 500; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            pll_lock = 1'b0;
            idle(int'($urandom_range(1, 3)));
            pll_lock = 1'b1;
            idle(LOCK_WAIT + 2);
         end else if (r < 4) begin
            idle(TMO + 4);
         end else if (r < 10) begin
            capture_en = ~capture_en;
            idle(1);
         end else if (r < 35) begin
            int s;
            s = int'($urandom_range(0, 9));
            short_pkt((s < 4) ? DT_FS : (s < 8) ? DT_FE : DT_LS, "rnd_sp");
            idle(int'($urandom_range(1, 2)));
         end else if (r < 85) begin
            send_line(($urandom_range(0, 3) != 0) ? DT_RAW10 : 6'h12,
                      16'($urandom_range(0, 24)), int'($urandom_range(0, 14)));
         end else begin
            idle(int'($urandom_range(1, 4)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
